// File: rtl/hazard_scheduler.sv
// Pipeline hazard unit: operand forwarding, load-use stalls, branch flushes and
// a data-memory wait freeze with a sticky timeout.
module hazard_scheduler #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemAckM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemTimeout,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEMWAIT,
        S_TIMEOUT
    } state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_next_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_freeze;
    logic        w_lduse;

    // Writeback is the older source, so Memory takes priority when both match.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    assign w_lduse  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // MEMWAIT ignores MemReqM: a request withdrawn before its ack still holds the freeze.
    assign w_freeze = ((r_state == S_RUN) && MemReqM && !MemAckM)
                   || ((r_state == S_MEMWAIT) && !MemAckM)
                   || (r_state == S_TIMEOUT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // NOTE: defaults at the top of every always_comb keep each path assigned,
    // so no latch is inferred.
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                if (MemReqM && !MemAckM) begin
                    w_next_state    = S_MEMWAIT;
                    w_next_wait_cnt = 8'd1;
                end else begin
                    w_next_wait_cnt = 8'd0;
                end
            end
            S_MEMWAIT: begin
                if (MemAckM) begin
                    w_next_state    = S_RUN;
                    w_next_wait_cnt = 8'd0;
                end else if (r_wait_cnt == LP_LAST_WAIT) begin
                    w_next_state    = S_TIMEOUT;
                end else begin
                    w_next_wait_cnt = r_wait_cnt + 8'd1;
                end
            end
            S_TIMEOUT: w_next_state = S_TIMEOUT;
            default: begin
                w_next_state    = S_RUN;
                w_next_wait_cnt = 8'd0;
            end
        endcase
    end

    // Freeze dominates, then a taken branch, then load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (w_freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lduse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign MemTimeout = (r_state == S_TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= 16'd0;
        else if (StallF && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler with hand-computed
// expectations for forwarding, load-use, branch, memory wait, timeout and reset.
module tb_hazard_scheduler;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemAckM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemTimeout;
    logic [15:0] StallCount;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scheduler #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCount(StallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stall/flush vector packed as {StallF,StallD,StallE,StallM,FlushD,FlushE}.
    function automatic logic [15:0] ctl();
        return {10'd0, StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
    endtask

    // Pulse reset between clock edges.
    task automatic pulse_reset();
        quiet_inputs();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        quiet_inputs();
        #2;
        reset = 1'b1;
        #1;
        check("reset_stallcount", StallCount, 16'd0);
        check("reset_timeout", {15'd0, MemTimeout}, 16'd0);
        check("reset_ctl", ctl(), 16'b000000);
        step();
        reset = 1'b0;
        step();

        // Forwarding priority
        Rs1E = 5'd5; Rs2E = 5'd6; RdM = 5'd5; RdW = 5'd5;
        RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        check("fwdA_mem", {14'd0, ForwardAE}, 16'd2);
        check("fwdB_none", {14'd0, ForwardBE}, 16'd0);
        RdM = 5'd0;
        #1;
        check("fwdA_wb_rdm0", {14'd0, ForwardAE}, 16'd1);
        RdM = 5'd5; RegWriteM = 1'b0;
        #1;
        check("fwdA_wb_nowrm", {14'd0, ForwardAE}, 16'd1);
        Rs2E = 5'd5; RegWriteM = 1'b1;
        #1;
        check("fwdB_mem", {14'd0, ForwardBE}, 16'd2);
        RdW = 5'd0; RegWriteM = 1'b0;
        #1;
        check("fwdA_rdw0", {14'd0, ForwardAE}, 16'd0);
        quiet_inputs();
        step();

        // Load-use
        ResultSrcE0 = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
        #1;
        check("lduse_ctl", ctl(), 16'b110001);
        step();
        check("lduse_count", StallCount, 16'd1);
        RdE = 5'd0; Rs2D = 5'd0;
        #1;
        check("lduse_rd0_ctl", ctl(), 16'b000000);
        RdE = 5'd3; Rs1D = 5'd3;
        #1;
        check("lduse_rs1_ctl", ctl(), 16'b110001);
        ResultSrcE0 = 1'b0;
        #1;
        check("no_load_ctl", ctl(), 16'b000000);
        step();
        check("no_load_count", StallCount, 16'd1);

        // Branch over load-use
        ResultSrcE0 = 1'b1; RdE = 5'd3; Rs2D = 5'd3; Rs1D = 5'd0; PCSrcE = 1'b1;
        #1;
        check("branch_ctl", ctl(), 16'b000011);
        step();
        check("branch_count", StallCount, 16'd1);
        quiet_inputs();
        step();

        // Memory wait of 3 cycles
        pulse_reset();
        MemReqM = 1'b1; MemAckM = 1'b0;
        #1;
        check("memwait_c1", ctl(), 16'b111100);
        step();
        check("memwait_c2", ctl(), 16'b111100);
        step();
        PCSrcE = 1'b1;
        #1;
        check("memwait_c3_branch", ctl(), 16'b111100);
        PCSrcE = 1'b0;
        step();
        MemAckM = 1'b1;
        #1;
        check("memwait_ack", ctl(), 16'b000000);
        step();
        check("memwait_count", StallCount, 16'd3);
        MemReqM = 1'b0; MemAckM = 1'b0;
        #1;
        check("memwait_run", ctl(), 16'b000000);
        step();
        check("memwait_count_hold", StallCount, 16'd3);

        // Timeout after 15 unacknowledged cycles
        pulse_reset();
        MemReqM = 1'b1; MemAckM = 1'b0;
        repeat (14) step();
        check("timeout_edge14", {15'd0, MemTimeout}, 16'd0);
        step();
        check("timeout_edge15", {15'd0, MemTimeout}, 16'd1);
        check("timeout_count", StallCount, 16'd15);
        MemReqM = 1'b0; MemAckM = 1'b1;
        #1;
        check("timeout_ack_ctl", ctl(), 16'b111100);
        step();
        check("timeout_sticky", {15'd0, MemTimeout}, 16'd1);
        check("timeout_count16", StallCount, 16'd16);
        repeat (65519) step();
        check("sat_reach", StallCount, 16'hFFFF);
        step();
        check("sat_hold", StallCount, 16'hFFFF);

        // Reset mid-wait with wait_cnt=7, request withdrawn before reset
        pulse_reset();
        MemReqM = 1'b1; MemAckM = 1'b0;
        repeat (7) step();
        MemReqM = 1'b0;
        #1;
        check("withdrawn_freeze", ctl(), 16'b111100);
        reset = 1'b1;
        #1;
        check("rst_mid_ctl", ctl(), 16'b000000);
        check("rst_mid_count", StallCount, 16'd0);
        check("rst_mid_timeout", {15'd0, MemTimeout}, 16'd0);
        ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
        #1;
        check("rst_lduse_ctl", ctl(), 16'b110001);
        ResultSrcE0 = 1'b0;
        #1;
        reset = 1'b0;
        step();
        check("post_rst_ctl", ctl(), 16'b000000);
        check("post_rst_count", StallCount, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 15, giving the number of consecutive unacknowledged data-memory cycles before timeout (legal range 2..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  5 each  source register numbers of the instruction in Decode
- Rs1E, Rs2E  in  5 each  source register numbers of the instruction in Execute
- RdE, RdM, RdW  in  5 each  destination register numbers in Execute, Memory and Writeback
- RegWriteM, RegWriteW  in  1 each  register-write enable in Memory and Writeback
- ResultSrcE0  in  1  the instruction in Execute is a load
- PCSrcE  in  1  branch taken or jump resolved in Execute
- MemReqM  in  1  data-memory access in the Memory stage
- MemAckM  in  1  data-memory acknowledge
- StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register of that stage
- FlushD, FlushE  out  1 each  clear the Decode or Execute pipeline register
- ForwardAE, ForwardBE  out  2 each  Execute operand source select
- MemTimeout  out  1  sticky memory-timeout flag
- StallCount  out  16  saturating count of stalled fetch cycles

Function
REQ-003 The block SHALL implement a state machine with states RUN, MEMWAIT and TIMEOUT, plus an 8-bit wait_cnt register.
REQ-004 ForwardAE SHALL be computed combinationally with this priority:
- 2'b10 if RegWriteM, RdM≠0 and RdM==Rs1E
- else 2'b01 if RegWriteW, RdW≠0 and RdW==Rs1E
- else 2'b00
REQ-005 ForwardBE SHALL use the same rule as REQ-004 with Rs2E in place of Rs1E.
REQ-006 Forwarding outputs SHALL be valid in every state.
REQ-007 freeze SHALL be defined as: (RUN and MemReqM and !MemAckM) or (MEMWAIT and !MemAckM) or TIMEOUT.
REQ-008 While freeze=1, StallF, StallD, StallE and StallM SHALL be 1, and FlushD and FlushE SHALL be 0.
REQ-009 lduse SHALL be defined as: ResultSrcE0, RdE≠0, and (RdE==Rs1D or RdE==Rs2D).
REQ-010 With freeze=0 and PCSrcE=1, FlushD=1 and FlushE=1 SHALL be asserted, all stalls SHALL be 0, and lduse SHALL be ignored (branch flush wins).
REQ-011 With freeze=0, PCSrcE=0 and lduse=1, StallF=1, StallD=1 and FlushE=1 SHALL be asserted, and StallE, StallM and FlushD SHALL be 0.
REQ-012 Otherwise, all stall and flush outputs SHALL be 0.
REQ-013 The stall and flush outputs of REQ-008 to REQ-012 SHALL be combinational from the inputs and the current state, with zero latency.
REQ-014 The state machine SHALL make these transitions on each clock edge:
- RUN: MemReqM and !MemAckM → MEMWAIT, wait_cnt←1; otherwise stay in RUN, wait_cnt←0.
- MEMWAIT: MemAckM → RUN, wait_cnt←0.
- MEMWAIT: !MemAckM and wait_cnt==TIMEOUT_CYC-1 → TIMEOUT.
- MEMWAIT: !MemAckM otherwise → wait_cnt←wait_cnt+1.
- TIMEOUT: stays in TIMEOUT until reset; MemAckM is ignored.
REQ-015 TIMEOUT SHALL therefore be entered on the edge that ends the TIMEOUT_CYC-th consecutive unacknowledged cycle.
REQ-016 MemTimeout SHALL equal (state==TIMEOUT), driven from the state register.
REQ-017 StallCount SHALL increment on every edge where StallF=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-018 MemReqM deasserting while in MEMWAIT without MemAckM SHALL still be treated as unacknowledged, and the freeze SHALL be held.
REQ-019 PCSrcE and lduse arriving while frozen SHALL take effect on the first non-frozen cycle, because the inputs are held by the stalled stages.

Reset
REQ-020 Reset SHALL immediately force state=RUN, wait_cnt=0, StallCount=0 and MemTimeout=0, regardless of clk.
REQ-021 Reset asserted mid-MEMWAIT or in TIMEOUT SHALL return the block to RUN with no residual freeze once the inputs are quiet.
REQ-022 During reset, the combinational outputs SHALL still follow REQ-004 to REQ-013, evaluated with state=RUN.

Verification
REQ-023 The bench SHALL cover forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10; RdM=0 → ForwardAE=01; Rs2E≠5 → ForwardBE=00.
REQ-024 The bench SHALL cover load-use: ResultSrcE0=1, RdE=3, Rs2D=3, PCSrcE=0 → StallF=StallD=FlushE=1 for one cycle, and StallCount increments by 1.
REQ-025 The bench SHALL cover branch over load-use: same as REQ-024 plus PCSrcE=1 → FlushD=FlushE=1, StallF=0, and StallCount unchanged.
REQ-026 The bench SHALL cover a memory wait: MemReqM=1, MemAckM=0 for 3 cycles then 1 → all four stalls high for exactly 3 cycles, state returns to RUN, and StallCount=3.
REQ-027 The bench SHALL cover timeout: MemReqM=1 and MemAckM=0 held for 15 cycles (default TIMEOUT_CYC) → MemTimeout=1 after the 15th edge, stalls stay high, and a later MemAckM=1 has no effect.
REQ-028 The bench SHALL cover reset mid-wait: reset pulsed asynchronously (between edges) in MEMWAIT with wait_cnt=7 → outputs immediately show RUN behaviour with StallCount=0 and MemTimeout=0.
